snn_timestep_scheduler: RTL and testbench
=========================================

# snn_timestep_scheduler

Sequencer for a two-layer spiking classifier built from two time-multiplexed LIF layer engines (input→hidden, hidden→output). Per inference it:
- clears both engines' membranes;
- accepts one input spike frame per timestep over a valid/ready handshake;
- starts layer 1, then layer 2, for each frame;
- counts output-layer spikes over T_STEPS timesteps;
- reports the arg-max class.

It sits between the host/encoder and the engine pair; the engines themselves are unchanged.

## Interface
- N_IN, 30: input spike frame width.
- N_HID, 30: layer-1 outputs = layer-2 inputs.
- N_OUT, 10: output neurons / classes.
- T_STEPS, 25: timesteps per inference (≥1).
- CNT_W, 8: per-class spike counter width, saturating.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1-cycle pulse; begins an inference when idle.
- busy  out  1  high from accepted run until class_valid.
- in_valid  in  1  input frame valid.
- in_ready  out  1  scheduler can accept a frame.
- in_bits  in  N_IN  input spike frame.
- eng_clr  out  1  1-cycle pulse; top ANDs it into both engines' rst_n as rst_n = ~(rst | eng_clr).
- l1_start  out  1  1-cycle start pulse to layer 1.
- l1_spikes_in  out  N_IN  latched frame, stable from l1_start until l1_done.
- l1_done  in  1  layer-1 done pulse.
- l1_spikes_out  in  N_HID  layer-1 output, valid in l1_done cycle.
- l2_start  out  1  1-cycle start pulse to layer 2.
- l2_spikes_in  out  N_HID  latched hidden spikes, stable from l2_start until l2_done.
- l2_done  in  1  layer-2 done pulse.
- l2_spikes_out  in  N_OUT  layer-2 output, valid in l2_done cycle.
- class_idx  out  $clog2(N_OUT)  winning class.
- class_valid  out  1  1-cycle pulse.
- spike_counts  out  N_OUT*CNT_W  per-class counts; class k at [k*CNT_W +: CNT_W]; held until next run.

## Operation
States: IDLE, CLEAR, WAIT_IN, L1_GO, L1_WAIT, L2_GO, L2_WAIT, ACCUM, ARGMAX, REPORT.

- **IDLE:** run → CLEAR; run while busy is ignored (no latch).
- **CLEAR:**
  - eng_clr=1 for exactly this cycle;
  - step counter, spike_counts, class_idx ← 0;
  - → WAIT_IN.
- **WAIT_IN:**
  - in_ready=1;
  - on in_valid, capture in_bits into l1_spikes_in → L1_GO;
  - in_ready is low in every other state.
- **L1_GO:** l1_start=1 → L1_WAIT.
- **L1_WAIT:** on l1_done, capture l1_spikes_out into l2_spikes_in → L2_GO.
- **L2_GO:** l2_start=1 → L2_WAIT.
- **L2_WAIT:** on l2_done, capture l2_spikes_out into an internal frame register → ACCUM.
- **ACCUM:**
  - each count[k] += frame[k], saturating at 2^CNT_W−1;
  - if step == T_STEPS−1 → ARGMAX, else step++ and → WAIT_IN.
- **ARGMAX:**
  - sequential scan, one class per cycle, k = 0..N_OUT−1;
  - strict greater-than compare, so a tie resolves to the lowest index;
  - all-zero counts give class 0;
  - → REPORT after the last index.
- **REPORT:** class_valid=1, busy=0 → IDLE.
- **Engine-done rules:**
  - done pulses outside the matching WAIT state are ignored;
  - the scheduler never issues a start while an engine is busy;
  - layers are strictly serialized (no overlap in this revision).
- **Reset value of every output:** 0 (busy, in_ready, eng_clr, starts, spikes_in regs, class_idx, class_valid, spike_counts).
- **Reset mid-inference:**
  - returns to IDLE next edge;
  - counts cleared;
  - no class_valid.

## Timing
- run sampled at edge N → CLEAR in cycle N+1 (eng_clr high, busy high) → in_ready high from N+2.
- Frame handshake edge E → l1_start high in cycle E+1.
- l1_done sampled at edge D → l2_start high in cycle D+1.
- l2_done at edge D2 → ACCUM in cycle D2+1 → in_ready high again in cycle D2+2; last step goes to ARGMAX instead.
- Scheduler overhead per timestep, excluding engine latency and host stall: 4 cycles.
- ARGMAX: N_OUT cycles; class_valid occurs N_OUT+1 cycles after the last ACCUM.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `snn_pkg`:
  - state enum;
  - IDX_W(n) width function, = 1 when n ≤ 2, else $clog2(n);
  - default T_STEPS, CNT_W.
- One natural sub-module: `spike_counter_bank`, holding the N_OUT saturating counters, clear, increment-by-frame, and flattened output.
- Argmax scan and FSM live in the top module.

## Test plan
- **Basic run:** T_STEPS=3, N_OUT=4, stub engines with done 5 cycles after start; l2 returns 4'b0010 every step → spike_counts class1=3, others 0; class_idx=1; one class_valid; eng_clr exactly once.
- **Tie break:** l2 outputs 4'b1001 every step → counts [3,0,0,3] → class_idx=0; all-zero outputs → class_idx=0.
- **Saturation:** CNT_W=2, T_STEPS=6, class 2 fires every step → count[2]=3, not wrapped; class_idx=2.
- **Handshake stall:** in_valid held low for 10 cycles in step 1 → in_ready stays high, no l1_start; l1_spikes_in equals the frame captured at the handshake and stays stable through l1_done.
- **Spurious/overlapping events:** run pulsed while busy, l2_done pulsed during L1_WAIT → both ignored; sequence and result identical to a clean run.
- **Reset mid-run:** rst asserted during L2_WAIT of step 2 → all outputs 0 next cycle, no class_valid; a following run completes normally with correct counts.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the two-layer spiking classifier sequencer.
package snn_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StWaitIn,
    StL1Go,
    StL1Wait,
    StL2Go,
    StL2Wait,
    StAccum,
    StArgmax,
    StReport
  } state_e;

  localparam int unsigned TStepsDefault = 25;
  localparam int unsigned CntWDefault   = 8;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int unsigned IDX_W(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snn_timestep_scheduler_if.sv
// Input spike frame stream between the host/encoder and the scheduler.
interface snn_timestep_scheduler_if #(
  parameter int unsigned N_IN = 30
) ();

  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_bits;

  modport master (
    output in_valid,
    output in_bits,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_bits,
    output in_ready
  );

endinterface

// File: rtl/spike_counter_bank.sv
// Per-class saturating spike counters with clear, frame increment and flat output.
module spike_counter_bank #(
  parameter int unsigned N_OUT = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   inc_i,
  input  logic [N_OUT-1:0]       frame_i,
  output logic [N_OUT*CNT_W-1:0] counts_o
);

  logic [N_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (frame_i[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign counts_o = cnt_q;

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences frame intake, serialized layer-1/layer-2 engine runs, spike counting and
// a one-class-per-cycle arg-max scan for a two-layer spiking classifier.
module snn_timestep_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned N_IN    = 30,
  parameter int unsigned N_HID   = 30,
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned T_STEPS = TStepsDefault,
  parameter int unsigned CNT_W   = CntWDefault
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  output logic                         busy,
  snn_timestep_scheduler_if.slave      in_if,
  output logic                         eng_clr,
  output logic                         l1_start,
  output logic [N_IN-1:0]              l1_spikes_in,
  input  logic                         l1_done,
  input  logic [N_HID-1:0]             l1_spikes_out,
  output logic                         l2_start,
  output logic [N_HID-1:0]             l2_spikes_in,
  input  logic                         l2_done,
  input  logic [N_OUT-1:0]             l2_spikes_out,
  output logic [IDX_W(N_OUT)-1:0]      class_idx,
  output logic                         class_valid,
  output logic [N_OUT*CNT_W-1:0]       spike_counts
);

  localparam int unsigned IdxW  = IDX_W(N_OUT);
  localparam int unsigned StepW = IDX_W(T_STEPS);
  localparam logic [StepW-1:0] LastStep = StepW'(T_STEPS - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N_OUT - 1);

  state_e state_q, state_d;
  logic   busy_q, in_ready_q, eng_clr_q, l1_start_q, l2_start_q, class_valid_q;

  logic [N_IN-1:0]  l1_in_q;
  logic [N_HID-1:0] l2_in_q;
  logic [N_OUT-1:0] frame_q;
  logic [StepW-1:0] step_q;
  logic [IdxW-1:0]  scan_q, best_idx_q, class_idx_q, win_idx;
  logic [CNT_W-1:0] best_q, cur_cnt, win_cnt;

  logic [N_OUT-1:0][CNT_W-1:0] counts_2d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (run) state_d = StClear;
      StClear:  state_d = StWaitIn;
      StWaitIn: if (in_if.in_valid) state_d = StL1Go;
      StL1Go:   state_d = StL1Wait;
      StL1Wait: if (l1_done) state_d = StL2Go;
      StL2Go:   state_d = StL2Wait;
      StL2Wait: if (l2_done) state_d = StAccum;
      StAccum:  state_d = (step_q == LastStep) ? StArgmax : StWaitIn;
      StArgmax: if (scan_q == LastIdx) state_d = StReport;
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      eng_clr_q     <= 1'b0;
      l1_start_q    <= 1'b0;
      l2_start_q    <= 1'b0;
      class_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != StIdle) && (state_d != StReport);
      in_ready_q    <= (state_d == StWaitIn);
      eng_clr_q     <= (state_d == StClear);
      l1_start_q    <= (state_d == StL1Go);
      l2_start_q    <= (state_d == StL2Go);
      class_valid_q <= (state_d == StReport);
    end
  end

  assign counts_2d = spike_counts;
  assign cur_cnt   = counts_2d[scan_q];
  // Strict compare keeps the earliest index on ties.
  assign win_idx   = (cur_cnt > best_q) ? scan_q  : best_idx_q;
  assign win_cnt   = (cur_cnt > best_q) ? cur_cnt : best_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      l1_in_q     <= '0;
      l2_in_q     <= '0;
      frame_q     <= '0;
      step_q      <= '0;
      scan_q      <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
    end else begin
      case (state_q)
        StClear: begin
          step_q      <= '0;
          class_idx_q <= '0;
        end
        StWaitIn: if (in_if.in_valid) l1_in_q <= in_if.in_bits;
        StL1Wait: if (l1_done) l2_in_q <= l1_spikes_out;
        StL2Wait: if (l2_done) frame_q <= l2_spikes_out;
        StAccum: begin
          if (step_q == LastStep) begin
            scan_q     <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
          end else begin
            step_q <= step_q + StepW'(1);
          end
        end
        StArgmax: begin
          best_q     <= win_cnt;
          best_idx_q <= win_idx;
          if (scan_q == LastIdx) begin
            class_idx_q <= win_idx;
          end else begin
            scan_q <= scan_q + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  spike_counter_bank #(
    .N_OUT (N_OUT),
    .CNT_W (CNT_W)
  ) u_counters (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (state_q == StClear),
    .inc_i    (state_q == StAccum),
    .frame_i  (frame_q),
    .counts_o (spike_counts)
  );

  assign busy           = busy_q;
  assign in_if.in_ready = in_ready_q;
  assign eng_clr        = eng_clr_q;
  assign l1_start       = l1_start_q;
  assign l1_spikes_in   = l1_in_q;
  assign l2_start       = l2_start_q;
  assign l2_spikes_in   = l2_in_q;
  assign class_idx      = class_idx_q;
  assign class_valid    = class_valid_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Bench: two scheduler instances (3-step/8-bit counters and 6-step/2-bit counters) with
// stub engines; directed vectors, corner sequences and a randomized reference model.
module tb_snn_timestep_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT A: T_STEPS=3, CNT_W=8 ----------------
  logic       rst_a, a_run, a_run_spur, a_busy, a_eng_clr;
  logic       a_l1_start, a_l1_done, a_l2_start, a_l2_done_stub, a_l2_spur, a_cv;
  logic [7:0] a_l1_in;
  logic [5:0] a_l1_out, a_l2_in;
  logic [3:0] a_l2_out;
  logic [1:0] a_idx;
  logic [31:0] a_counts;
  logic [2:0] a_l1_cnt, a_l2_cnt;

  snn_timestep_scheduler_if #(.N_IN(8)) a_if ();

  snn_timestep_scheduler #(
    .N_IN(8), .N_HID(6), .N_OUT(4), .T_STEPS(3), .CNT_W(8)
  ) dut_a (
    .clk           (clk),
    .rst           (rst_a),
    .run           (a_run | a_run_spur),
    .busy          (a_busy),
    .in_if         (a_if),
    .eng_clr       (a_eng_clr),
    .l1_start      (a_l1_start),
    .l1_spikes_in  (a_l1_in),
    .l1_done       (a_l1_done),
    .l1_spikes_out (a_l1_out),
    .l2_start      (a_l2_start),
    .l2_spikes_in  (a_l2_in),
    .l2_done       (a_l2_done_stub | a_l2_spur),
    .l2_spikes_out (a_l2_out),
    .class_idx     (a_idx),
    .class_valid   (a_cv),
    .spike_counts  (a_counts)
  );

  // Stub engines: done 5 cycles after start; outputs are fixed maps of the latched inputs.
  always_ff @(posedge clk) begin
    if (rst_a || a_eng_clr) begin
      a_l1_cnt <= '0; a_l2_cnt <= '0; a_l1_done <= 1'b0; a_l2_done_stub <= 1'b0;
      a_l1_out <= '0; a_l2_out <= '0;
    end else begin
      a_l1_done      <= 1'b0;
      a_l2_done_stub <= 1'b0;
      if (a_l1_start) a_l1_cnt <= 3'd5;
      else if (a_l1_cnt != 3'd0) begin
        a_l1_cnt <= a_l1_cnt - 3'd1;
        if (a_l1_cnt == 3'd1) begin
          a_l1_done <= 1'b1;
          a_l1_out  <= a_l1_in[5:0] ^ {4'b0, a_l1_in[7:6]};
        end
      end
      if (a_l2_start) a_l2_cnt <= 3'd5;
      else if (a_l2_cnt != 3'd0) begin
        a_l2_cnt <= a_l2_cnt - 3'd1;
        if (a_l2_cnt == 3'd1) begin
          a_l2_done_stub <= 1'b1;
          a_l2_out       <= a_l2_in[3:0] ^ {2'b0, a_l2_in[5:4]};
        end
      end
    end
  end

  int a_clr_cnt = 0, a_cv_cnt = 0, a_l1s_cnt = 0;
  always_ff @(posedge clk) begin
    if (a_eng_clr)  a_clr_cnt <= a_clr_cnt + 1;
    if (a_cv)       a_cv_cnt  <= a_cv_cnt + 1;
    if (a_l1_start) a_l1s_cnt <= a_l1s_cnt + 1;
  end

  // ---------------- DUT B: T_STEPS=6, CNT_W=2 ----------------
  logic       rst_b, b_run, b_busy, b_eng_clr, b_l1_start, b_l1_done, b_l2_start, b_l2_done;
  logic       b_cv;
  logic [7:0] b_l1_in;
  logic [5:0] b_l1_out, b_l2_in;
  logic [3:0] b_l2_out;
  logic [1:0] b_idx;
  logic [7:0] b_counts;
  logic [2:0] b_l1_cnt, b_l2_cnt;

  snn_timestep_scheduler_if #(.N_IN(8)) b_if ();

  snn_timestep_scheduler #(
    .N_IN(8), .N_HID(6), .N_OUT(4), .T_STEPS(6), .CNT_W(2)
  ) dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .run           (b_run),
    .busy          (b_busy),
    .in_if         (b_if),
    .eng_clr       (b_eng_clr),
    .l1_start      (b_l1_start),
    .l1_spikes_in  (b_l1_in),
    .l1_done       (b_l1_done),
    .l1_spikes_out (b_l1_out),
    .l2_start      (b_l2_start),
    .l2_spikes_in  (b_l2_in),
    .l2_done       (b_l2_done),
    .l2_spikes_out (b_l2_out),
    .class_idx     (b_idx),
    .class_valid   (b_cv),
    .spike_counts  (b_counts)
  );

  always_ff @(posedge clk) begin
    if (rst_b || b_eng_clr) begin
      b_l1_cnt <= '0; b_l2_cnt <= '0; b_l1_done <= 1'b0; b_l2_done <= 1'b0;
      b_l1_out <= '0; b_l2_out <= '0;
    end else begin
      b_l1_done <= 1'b0;
      b_l2_done <= 1'b0;
      if (b_l1_start) b_l1_cnt <= 3'd5;
      else if (b_l1_cnt != 3'd0) begin
        b_l1_cnt <= b_l1_cnt - 3'd1;
        if (b_l1_cnt == 3'd1) begin
          b_l1_done <= 1'b1;
          b_l1_out  <= b_l1_in[5:0] ^ {4'b0, b_l1_in[7:6]};
        end
      end
      if (b_l2_start) b_l2_cnt <= 3'd5;
      else if (b_l2_cnt != 3'd0) begin
        b_l2_cnt <= b_l2_cnt - 3'd1;
        if (b_l2_cnt == 3'd1) begin
          b_l2_done <= 1'b1;
          b_l2_out  <= b_l2_in[3:0] ^ {2'b0, b_l2_in[5:4]};
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Engine pair behaviour seen end to end: output classes fired for one input frame.
  function automatic logic [3:0] engines(input logic [7:0] x);
    logic [5:0] h;
    h = x[5:0] ^ {4'b0, x[7:6]};
    return h[3:0] ^ {2'b0, h[5:4]};
  endfunction

  // Reference: per-class spike totals clipped at maxc; winner is the lowest index of the max.
  task automatic model(input logic [47:0] frames, input int nsteps, input int maxc,
                       output logic [31:0] counts, output logic [1:0] idx);
    int c[4];
    int mx;
    logic [3:0] o;
    for (int k = 0; k < 4; k++) c[k] = 0;
    for (int s = 0; s < nsteps; s++) begin
      o = engines(frames[s*8 +: 8]);
      for (int k = 0; k < 4; k++) if (o[k]) c[k] = c[k] + 1;
    end
    mx = 0;
    for (int k = 0; k < 4; k++) begin
      if (c[k] > maxc) c[k] = maxc;
      if (c[k] > mx) mx = c[k];
      counts[k*8 +: 8] = 8'(c[k]);
    end
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) if (c[k] == mx) idx = 2'(k);
  endtask

  // One inference on DUT A with optional timing checks, a stall, or a reset in L2_WAIT.
  task automatic run_a(input logic [23:0] frames, input int stall_step, input int stall_len,
                       input bit chk_timing, input int rst_step,
                       output logic [31:0] counts, output logic [1:0] idx);
    int n;
    int clr0, cv0, l1s0;
    bit flag;
    counts = '0;
    idx    = '0;
    clr0 = a_clr_cnt; cv0 = a_cv_cnt; l1s0 = a_l1s_cnt;
    @(negedge clk); a_run = 1'b1;
    @(negedge clk); a_run = 1'b0;
    if (chk_timing) begin
      check("clear_cycle", {a_eng_clr, a_busy, a_if.in_ready}, 3'b110);
      @(negedge clk);
      check("ready_cycle", {a_eng_clr, a_busy, a_if.in_ready}, 3'b011);
    end
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (!a_if.in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin fail_now("a_in_ready"); return; end
      if (s == stall_step) begin
        flag = 1'b0;
        for (int i = 0; i < stall_len; i++) begin
          if (!a_if.in_ready || a_l1_start) flag = 1'b1;
          @(negedge clk);
        end
        check("stall_hold", {63'b0, flag}, 64'd0);
      end
      a_if.in_valid = 1'b1;
      a_if.in_bits  = frames[s*8 +: 8];
      @(negedge clk);
      a_if.in_valid = 1'b0;
      a_if.in_bits  = 8'($urandom());
      if (chk_timing && s == 0) check("l1_start_next", {63'b0, a_l1_start}, 64'd1);
      if (s == stall_step) begin
        flag = 1'b0;
        n = 0;
        while (!a_l1_done && n < 50) begin
          if (a_l1_in !== frames[s*8 +: 8]) flag = 1'b1;
          @(negedge clk);
          n++;
        end
        if (a_l1_in !== frames[s*8 +: 8] || n >= 50) flag = 1'b1;
        check("l1_in_stable", {63'b0, flag}, 64'd0);
      end
      if (s == rst_step) begin
        n = 0;
        while (!a_l2_start && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin fail_now("a_l2_start"); return; end
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("rst_outputs", {a_busy, a_if.in_ready, a_eng_clr, a_l1_start, a_l1_in,
                              a_l2_start, a_l2_in, a_idx, a_cv, a_counts}, 64'd0);
        cv0 = a_cv_cnt;
        repeat (40) @(negedge clk);
        check("rst_no_valid", 64'(a_cv_cnt - cv0), 64'd0);
        check("rst_idle", {a_busy, a_counts}, 64'd0);
        return;
      end
    end
    n = 0;
    while (!a_cv && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin fail_now("a_class_valid"); return; end
    counts = a_counts;
    idx    = a_idx;
    check("busy_at_valid", {63'b0, a_busy}, 64'd0);
    @(negedge clk);
    check("pulse_counts", {32'(a_clr_cnt - clr0), 16'(a_cv_cnt - cv0), 16'(a_l1s_cnt - l1s0)},
          {32'd1, 16'd1, 16'd3});
  endtask

  task automatic run_b(input logic [47:0] frames, output logic [31:0] counts,
                       output logic [1:0] idx);
    int n;
    counts = '0;
    idx    = '0;
    @(negedge clk); b_run = 1'b1;
    @(negedge clk); b_run = 1'b0;
    for (int s = 0; s < 6; s++) begin
      n = 0;
      while (!b_if.in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin fail_now("b_in_ready"); return; end
      b_if.in_valid = 1'b1;
      b_if.in_bits  = frames[s*8 +: 8];
      @(negedge clk);
      b_if.in_valid = 1'b0;
    end
    n = 0;
    while (!b_cv && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin fail_now("b_class_valid"); return; end
    for (int k = 0; k < 4; k++) counts[k*8 +: 8] = {6'b0, b_counts[k*2 +: 2]};
    idx = b_idx;
  endtask

  typedef struct packed {
    logic [23:0] frames;      // {step2, step1, step0}
    int          stall_step;
    int          stall_len;
    logic [31:0] exp_counts;  // class k at [k*8 +: 8]
    logic [1:0]  exp_idx;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] got_c, exp_c;
  logic [1:0]  got_i, exp_i;
  logic [23:0] rf;
  logic [47:0] rb;
  int          st_step, st_len;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{24'h02_02_02, -1, 0,  32'h0000_0300, 2'd1};  // class 1 every step
    vecs[1] = '{24'h09_09_09,  1, 10, 32'h0300_0003, 2'd0};  // tie 0/3, stalled step 1
    vecs[2] = '{24'h00_00_00, -1, 0,  32'h0000_0000, 2'd0};  // no spikes
    vecs[3] = '{24'h08_0C_04, -1, 0,  32'h0202_0000, 2'd2};  // tie 2/3
    vecs[4] = '{24'h80_31_40,  0, 3,  32'h0000_0201, 2'd1};  // high input bits fold in

    rst_a = 1'b1; rst_b = 1'b1;
    a_run = 1'b0; a_run_spur = 1'b0; a_l2_spur = 1'b0; b_run = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_bits = '0;
    b_if.in_valid = 1'b0; b_if.in_bits = '0;
    repeat (3) @(negedge clk);
    check("reset_a", {a_busy, a_if.in_ready, a_eng_clr, a_l1_start, a_l1_in, a_l2_start,
                      a_l2_in, a_idx, a_cv, a_counts}, 64'd0);
    check("reset_b", {b_busy, b_if.in_ready, b_eng_clr, b_l1_start, b_l1_in, b_l2_start,
                      b_l2_in, b_idx, b_cv, b_counts}, 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_a", {a_busy, a_if.in_ready, a_eng_clr, a_cv, a_counts}, 64'd0);

    for (int i = 0; i < 5; i++) begin
      run_a(vecs[i].frames, vecs[i].stall_step, vecs[i].stall_len, i == 0, -1, got_c, got_i);
      check($sformatf("vec%0d_counts", i), 64'(got_c), 64'(vecs[i].exp_counts));
      check($sformatf("vec%0d_idx", i), 64'(got_i), 64'(vecs[i].exp_idx));
      repeat (3) @(negedge clk);
    end

    // Spurious run and l2_done while waiting on layer 1.
    fork
      run_a(vecs[0].frames, -1, 0, 1'b0, -1, got_c, got_i);
      begin : inject
        int n;
        n = 0;
        while (!a_l1_start && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        @(negedge clk);
        a_l2_spur = 1'b1; a_run_spur = 1'b1;
        @(negedge clk);
        a_l2_spur = 1'b0; a_run_spur = 1'b0;
      end
    join
    check("spur_counts", 64'(got_c), 64'(vecs[0].exp_counts));
    check("spur_idx", 64'(got_i), 64'(vecs[0].exp_idx));
    repeat (3) @(negedge clk);

    // Reset during L2_WAIT of the second step, then a clean inference.
    run_a(vecs[3].frames, -1, 0, 1'b0, 1, got_c, got_i);
    run_a(vecs[3].frames, -1, 0, 1'b0, -1, got_c, got_i);
    check("post_rst_counts", 64'(got_c), 64'(vecs[3].exp_counts));
    check("post_rst_idx", 64'(got_i), 64'(vecs[3].exp_idx));

    for (int r = 0; r < 20; r++) begin
      rf      = 24'($urandom());
      st_step = int'($urandom_range(0, 2));
      st_len  = int'($urandom_range(0, 4));
      model({24'b0, rf}, 3, 255, exp_c, exp_i);
      run_a(rf, st_step, st_len, 1'b0, -1, got_c, got_i);
      check($sformatf("rand%0d_counts", r), 64'(got_c), 64'(exp_c));
      check($sformatf("rand%0d_idx", r), 64'(got_i), 64'(exp_i));
    end

    // Saturation: class 2 fires in all six steps of a 2-bit counter.
    run_b({6{8'h04}}, got_c, got_i);
    check("sat_counts", 64'(got_c), 64'h0003_0000);
    check("sat_idx", 64'(got_i), 64'd2);

    for (int r = 0; r < 6; r++) begin
      rb = {16'($urandom()), 32'($urandom())};
      model(rb, 6, 3, exp_c, exp_i);
      run_b(rb, got_c, got_i);
      check($sformatf("brand%0d_counts", r), 64'(got_c), 64'(exp_c));
      check($sformatf("brand%0d_idx", r), 64'(got_i), 64'(exp_i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
